// File: rtl/joypad_pkg.sv
// -----------------------------------------------------------------------------
// joypad_pkg
// Shared types and constants for the Game Boy P1/JOYP joypad register.
//   btn_idx_t   : bit positions of the eight debounced buttons on btn[7:0]
//   P1_ADDR_DEF : default bus address of the P1 register
//   SEL_RESET   : reset value of the two select bits (nothing selected)
//   irq_state_t : joypad interrupt request FSM states
// -----------------------------------------------------------------------------
package joypad_pkg;

    typedef enum logic [2:0] {
        BTN_RIGHT  = 3'd0,
        BTN_LEFT   = 3'd1,
        BTN_UP     = 3'd2,
        BTN_DOWN   = 3'd3,
        BTN_A      = 3'd4,
        BTN_B      = 3'd5,
        BTN_SELECT = 3'd6,
        BTN_START  = 3'd7
    } btn_idx_t;

    localparam logic [15:0] P1_ADDR_DEF = 16'hFF00;
    localparam logic [1:0]  SEL_RESET   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        GAP  = 2'd2
    } irq_state_t;

endpackage

// File: rtl/joypad_edge_det.sv
// -----------------------------------------------------------------------------
// joypad_edge_det
// Remembers last cycle's active-low matrix nibble and flags any line that
// went from released (1) to pressed (0).
// Ports:
//   clk     : system clock
//   reset   : synchronous, active-high; previous nibble returns to 4'hF
//   i_nib   : current active-low matrix nibble
//   o_fall  : combinational, high while any nibble bit is falling
// -----------------------------------------------------------------------------
module joypad_edge_det (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_nib,
    output logic       o_fall
);

    logic [3:0] r_prev_nib;

    // NOTE: state is written with non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_nib <= 4'hF;
        end else begin
            r_prev_nib <= i_nib;
        end
    end

    assign o_fall = |(r_prev_nib & ~i_nib);

endmodule

// File: rtl/joypad_ctrl.sv
// -----------------------------------------------------------------------------
// joypad_ctrl
// Game Boy P1/JOYP register: holds the CPU-written select bits, builds the
// active-low matrix nibble from the debounced buttons, returns it on reads and
// raises a level joypad interrupt on falling nibble lines, spaced by at least
// IRQ_MIN_GAP cycles after each acknowledge.
// Optional build macro: JOYPAD_SOCD_EN - clean opposite directions
// (Left+Right both released, Up/Down last-pressed wins).
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   btn[7:0]     : debounced buttons, 1=pressed (see btn_idx_t)
//   addr, wr_en, rd_en, wdata : CPU bus access
//   rdata        : registered P1 read data
//   rdata_valid  : high one cycle after a decoded read
//   irq_req      : joypad interrupt request (level)
//   irq_ack      : one-cycle acknowledge from the interrupt controller
// -----------------------------------------------------------------------------
module joypad_ctrl
    import joypad_pkg::*;
#(
    parameter logic [15:0] P1_ADDR     = P1_ADDR_DEF,
    parameter int          IRQ_MIN_GAP = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  btn,
    input  logic [15:0] addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        irq_req,
    input  logic        irq_ack
);

    localparam int                CNT_W    = $clog2(IRQ_MIN_GAP + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IRQ_MIN_GAP - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [1:0]       r_sel;
    logic [7:0]       r_rdata;
    logic             r_rdata_valid;
    irq_state_t       r_state;
    logic             r_irq_req;
    logic [CNT_W-1:0] r_gap_cnt;
    logic             r_fall_pend;

    logic       w_p1_hit;
    logic       w_right, w_left, w_up, w_down;
    logic [3:0] w_dir, w_act, w_nib;
    logic       w_fall;
    logic       w_unused;

    // Only the select bits of a P1 write are stored.
    assign w_unused = ^{wdata[7:6], wdata[3:0]};
    assign w_p1_hit = (addr == P1_ADDR);

`ifdef JOYPAD_SOCD_EN
    logic r_up_d, r_down_d;
    logic r_ud_last;            // 0 = Up pressed last, 1 = Down pressed last
    logic w_ud_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_up_d    <= 1'b0;
            r_down_d  <= 1'b0;
            r_ud_last <= 1'b0;
        end else begin
            r_up_d    <= btn[BTN_UP];
            r_down_d  <= btn[BTN_DOWN];
            r_ud_last <= w_ud_last;
        end
    end

    // The winner is taken from this cycle's rising edge so the cleaned
    // direction switches in the same cycle the second button lands.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_ud_last = r_ud_last;
        if (btn[BTN_DOWN] && !r_down_d) begin
            w_ud_last = 1'b1;
        end else if (btn[BTN_UP] && !r_up_d) begin
            w_ud_last = 1'b0;
        end
    end

    assign w_right = btn[BTN_RIGHT] & ~btn[BTN_LEFT];
    assign w_left  = btn[BTN_LEFT]  & ~btn[BTN_RIGHT];
    assign w_up    = btn[BTN_UP]    & ~(btn[BTN_DOWN] &  w_ud_last);
    assign w_down  = btn[BTN_DOWN]  & ~(btn[BTN_UP]   & ~w_ud_last);
`else
    assign w_right = btn[BTN_RIGHT];
    assign w_left  = btn[BTN_LEFT];
    assign w_up    = btn[BTN_UP];
    assign w_down  = btn[BTN_DOWN];
`endif

    // Active-low matrix: a select bit of 0 enables its button group.
    assign w_dir = ~{w_down, w_up, w_left, w_right};
    assign w_act = ~{btn[BTN_START], btn[BTN_SELECT], btn[BTN_B], btn[BTN_A]};
    assign w_nib = (r_sel[0] ? 4'hF : w_dir) & (r_sel[1] ? 4'hF : w_act);

    joypad_edge_det u_edge_det (
        .clk    (clk),
        .reset  (reset),
        .i_nib  (w_nib),
        .o_fall (w_fall)
    );

    // Bus side: a read in the same cycle as a write sees the old select bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel         <= SEL_RESET;
            r_rdata       <= 8'hFF;
            r_rdata_valid <= 1'b0;
        end else begin
            if (wr_en && w_p1_hit) begin
                r_sel <= wdata[5:4];
            end
            r_rdata_valid <= rd_en && w_p1_hit;
            if (rd_en && w_p1_hit) begin
                r_rdata <= {2'b11, r_sel, w_nib};
            end
        end
    end

    // Interrupt FSM. irq_req is registered alongside the state so it changes
    // on the same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_irq_req   <= 1'b0;
            r_gap_cnt   <= '0;
            r_fall_pend <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state   <= PEND;
                        r_irq_req <= 1'b1;
                    end
                end
                PEND: begin
                    // Falls while pending merge into the same request; a fall
                    // coinciding with the ack is carried into the gap.
                    if (irq_ack) begin
                        r_state     <= GAP;
                        r_irq_req   <= 1'b0;
                        r_gap_cnt   <= '0;
                        r_fall_pend <= w_fall;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == CNT_LAST) begin
                        r_fall_pend <= 1'b0;
                        if (r_fall_pend || w_fall) begin
                            r_state   <= PEND;
                            r_irq_req <= 1'b1;
                        end else begin
                            r_state   <= IDLE;
                        end
                    end else begin
                        if (r_gap_cnt != CNT_MAX) begin
                            r_gap_cnt <= r_gap_cnt + CNT_W'(1);
                        end
                        if (w_fall) begin
                            r_fall_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_irq_req <= 1'b0;
                end
            endcase
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign irq_req     = r_irq_req;

endmodule

// File: tb/tb_joypad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_joypad_ctrl
// Directed bench for joypad_ctrl (IRQ_MIN_GAP=16). Expected read data is
// queued when a read is issued and compared when rdata_valid appears.
// The SOCD section is compiled only when JOYPAD_SOCD_EN is defined.
// -----------------------------------------------------------------------------
module tb_joypad_ctrl;
    import joypad_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  btn;
    logic [15:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        irq_req;
    logic        irq_ack;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    joypad_ctrl #(
        .P1_ADDR     (16'hFF00),
        .IRQ_MIN_GAP (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .addr        (addr),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .irq_req     (irq_req),
        .irq_ack     (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic p1_write(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    // Read P1, optionally with a simultaneous write of wd.
    task automatic p1_read(input string tag, input logic [7:0] exp,
                           input bit with_wr, input logic [7:0] wd);
        logic [7:0] e;
        addr  = 16'hFF00;
        rd_en = 1'b1;
        wr_en = with_wr;
        wdata = wd;
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        check({tag, " valid"}, {31'd0, rdata_valid}, 32'd1);
        e = exp_q.pop_front();
        check(tag, {24'd0, rdata}, {24'd0, e});
        tick();
        check({tag, " valid drop"}, {31'd0, rdata_valid}, 32'd0);
        check({tag, " hold"}, {24'd0, rdata}, {24'd0, e});
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        btn     = 8'h00;
        addr    = 16'h0000;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wdata   = 8'h00;
        irq_ack = 1'b0;
        tick();
        tick();
        check("reset rdata", {24'd0, rdata}, 32'hFF);
        check("reset valid", {31'd0, rdata_valid}, 32'd0);
        check("reset irq", {31'd0, irq_req}, 32'd0);
        reset = 1'b0;
        tick();

        // Reset read
        p1_read("read after reset", 8'hFF, 1'b0, 8'h00);
        check("irq idle", {31'd0, irq_req}, 32'd0);

        // Direction group, press Right
        p1_write(16'hFF00, 8'h20);
        check("no irq after sel", {31'd0, irq_req}, 32'd0);
        btn[BTN_RIGHT] = 1'b1;
        check("irq not before edge", {31'd0, irq_req}, 32'd0);
        tick();
        check("irq on Right", {31'd0, irq_req}, 32'd1);
        p1_read("read Right", 8'hEE, 1'b0, 8'h00);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("irq drop on ack", {31'd0, irq_req}, 32'd0);
        repeat (20) tick();
        check("irq quiet after gap", {31'd0, irq_req}, 32'd0);

        // Nothing selected hides A; selecting actions exposes it
        btn[BTN_RIGHT] = 1'b0;
        p1_write(16'hFF00, 8'h30);
        btn[BTN_A] = 1'b1;
        tick();
        tick();
        check("A hidden no irq", {31'd0, irq_req}, 32'd0);
        p1_write(16'hFF00, 8'h10);
        check("irq not yet after write", {31'd0, irq_req}, 32'd0);
        tick();
        check("irq from select change", {31'd0, irq_req}, 32'd1);
        p1_read("read A", 8'hDE, 1'b0, 8'h00);

        // Ack, then Start 3 cycles later: reassert exactly 16 cycles after ack
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack before gap", {31'd0, irq_req}, 32'd0);
        n = 0;
        while (irq_req !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n == 3) btn[BTN_START] = 1'b1;
        end
        check("gap length Start", n, 32'd16);

        // Fall and ack in the same PEND cycle
        btn[BTN_B] = 1'b1;
        irq_ack    = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("fall+ack drops irq", {31'd0, irq_req}, 32'd0);
        n = 0;
        while (irq_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("gap length fall+ack", n, 32'd16);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        repeat (20) tick();
        check("no spurious irq", {31'd0, irq_req}, 32'd0);

        // Write and read in the same cycle return the old select bits
        p1_read("wr+rd old sel", 8'hD4, 1'b1, 8'h20);
        p1_read("read new sel", 8'hEF, 1'b0, 8'h00);
        check("release-only no irq", {31'd0, irq_req}, 32'd0);

        // Accesses to another address are ignored
        p1_write(16'hFF01, 8'h00);
        addr  = 16'hFF01;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("foreign read no valid", {31'd0, rdata_valid}, 32'd0);
        p1_read("sel after foreign wr", 8'hEF, 1'b0, 8'h00);

        // Reset in the middle of a pending request
        btn[BTN_DOWN] = 1'b1;
        tick();
        check("irq on Down", {31'd0, irq_req}, 32'd1);
        reset = 1'b1;
        tick();
        check("reset drops irq", {31'd0, irq_req}, 32'd0);
        check("reset rdata again", {24'd0, rdata}, 32'hFF);
        reset = 1'b0;
        tick();
        tick();
        check("no fall after reset", {31'd0, irq_req}, 32'd0);
        p1_read("read after mid reset", 8'hFF, 1'b0, 8'h00);

`ifdef JOYPAD_SOCD_EN
        btn = 8'h00;
        p1_write(16'hFF00, 8'h20);
        btn[BTN_LEFT]  = 1'b1;
        btn[BTN_RIGHT] = 1'b1;
        tick();
        p1_read("socd left+right", 8'hEF, 1'b0, 8'h00);
        btn = 8'h00;
        btn[BTN_UP] = 1'b1;
        tick();
        btn[BTN_DOWN] = 1'b1;
        tick();
        p1_read("socd down wins", 8'hE7, 1'b0, 8'h00);
        btn[BTN_DOWN] = 1'b0;
        tick();
        p1_read("socd up after release", 8'hEB, 1'b0, 8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
